// File: rtl/output_collector.sv
// Output-layer sink: captures one signed score per lane, runs a sequential argmax once every
// lane has arrived, and offers the winning class on a valid/ready handshake.
module output_collector #(
  parameter int N_OUT  = 10,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_OUT-1:0]        relu_valid,
  input  logic [N_OUT*DATA_W-1:0] relu_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [IDX_W-1:0]        res_class,
  output logic [DATA_W-1:0]       res_max,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic [1:0] {COLLECT, ARGMAX, HOLD} state_t;

  state_t                   state, state_nxt;
  logic [N_OUT-1:0]         mask;
  logic signed [DATA_W-1:0] score [N_OUT];
  // One wider than IDX_W so the final write-back step (cnt == N_OUT) is representable
  logic [IDX_W:0]           cnt;
  logic signed [DATA_W-1:0] best;
  logic [IDX_W-1:0]         best_idx;
  logic signed [DATA_W-1:0] cur;

  assign busy = (state != COLLECT);

  always_comb begin
    cur = '0;
    for (int unsigned i = 0; i < N_OUT; i++)
      if (cnt == (IDX_W+1)'(i)) cur = score[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (&(mask | relu_valid)) state_nxt = ARGMAX;
      ARGMAX:  if (cnt == (IDX_W+1)'(N_OUT)) state_nxt = HOLD;
      HOLD:    if (res_valid && res_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask      <= '0;
      cnt       <= '0;
      best      <= '0;
      best_idx  <= '0;
      res_valid <= 1'b0;
      res_class <= '0;
      res_max   <= '0;
      overrun   <= 1'b0;
      for (int unsigned i = 0; i < N_OUT; i++) score[i] <= '0;
    end else begin
      case (state)
        COLLECT: begin
          cnt <= '0;
          for (int unsigned i = 0; i < N_OUT; i++)
            if (relu_valid[i] && !mask[i]) score[i] <= relu_data[i*DATA_W +: DATA_W];
          mask <= mask | relu_valid;
          if (|(relu_valid & mask)) overrun <= 1'b1;
        end
        ARGMAX: begin
          if (|relu_valid) overrun <= 1'b1;
          cnt <= cnt + 1'b1;
          if (cnt == '0) begin
            best     <= cur;
            best_idx <= '0;
          end else if (cnt < (IDX_W+1)'(N_OUT)) begin
            if (cur > best) begin
              best     <= cur;
              best_idx <= cnt[IDX_W-1:0];
            end
          end else begin
            res_class <= best_idx;
            res_max   <= best;
            res_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (|relu_valid) overrun <= 1'b1;
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            mask      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
